// File: rtl/fifo_pkg.sv
// Shared constants for the FIFO family: read-mode selectors and default geometry.
package fifo_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  localparam int FIFO_DEFAULT_DATA_WIDTH = 8;
  localparam int FIFO_DEFAULT_ADDR_WIDTH = 4;

endpackage

// File: rtl/fifo_mem_2p.sv
// Two-port register array for the FIFO: synchronous write, asynchronous read.
module fifo_mem_2p
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = FIFO_DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  // Contents are deliberately left unreset; pointers alone define validity.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with programmable almost-full/empty thresholds, sticky
// error flags, synchronous flush and selectable standard or FWFT read port.
module sync_fifo_prog
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = FIFO_DEFAULT_ADDR_WIDTH,
  parameter int FWFT       = FIFO_MODE_STD,
  parameter int AF_LEVEL   = 12,
  parameter int AE_LEVEL   = 4
) (
  input  logic                  clk,
  input  logic                  resetb,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  input  logic                  flush,
  input  logic                  clr_err,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] AF_CNT = (ADDR_WIDTH + 1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_CNT = (ADDR_WIDTH + 1)'(AE_LEVEL);

  generate
    if (AF_LEVEL > DEPTH || AF_LEVEL <= AE_LEVEL) begin : g_bad_af
      $error("sync_fifo_prog: AF_LEVEL must satisfy AE_LEVEL < AF_LEVEL <= DEPTH");
    end
    if (AE_LEVEL < 0) begin : g_bad_ae
      $error("sync_fifo_prog: AE_LEVEL must be non-negative");
    end
  endgenerate

  logic [ADDR_WIDTH:0]   wr_ptr_reg, wr_ptr_next;
  logic [ADDR_WIDTH:0]   rd_ptr_reg, rd_ptr_next;
  logic [ADDR_WIDTH:0]   count_reg,  count_next;
  logic                  overflow_reg, underflow_reg;
  logic                  wr_accept, rd_accept;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Flags decode only registered state so no request input reaches them.
  assign full  = (wr_ptr_reg[ADDR_WIDTH] != rd_ptr_reg[ADDR_WIDTH]) &&
                 (wr_ptr_reg[ADDR_WIDTH-1:0] == rd_ptr_reg[ADDR_WIDTH-1:0]);
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign almost_full  = (count_reg >= AF_CNT);
  assign almost_empty = (count_reg <= AE_CNT);
  assign count     = count_reg;
  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;

  assign wr_accept = wr_en & ~full  & ~flush;
  assign rd_accept = rd_en & ~empty & ~flush;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (wr_accept) wr_ptr_next = wr_ptr_reg + 1'b1;
      if (rd_accept) rd_ptr_next = rd_ptr_reg + 1'b1;
      case ({wr_accept, rd_accept})
        2'b10:   count_next = count_reg + 1'b1;
        2'b01:   count_next = count_reg - 1'b1;
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      // Set has priority over clr_err when both occur together.
      if (wr_en & full & ~flush)      overflow_reg <= 1'b1;
      else if (clr_err)               overflow_reg <= 1'b0;
      if (rd_en & empty & ~flush)     underflow_reg <= 1'b1;
      else if (clr_err)               underflow_reg <= 1'b0;
    end
  end

  fifo_mem_2p #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_accept),
    .waddr (wr_ptr_reg[ADDR_WIDTH-1:0]),
    .wdata (din),
    .raddr (rd_ptr_reg[ADDR_WIDTH-1:0]),
    .rdata (mem_rdata)
  );

  generate
    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
      assign dout     = mem_rdata;
      assign rd_valid = ~empty;
    end else begin : g_std
      logic [DATA_WIDTH-1:0] dout_reg;
      logic                  rd_valid_reg;

      always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
          dout_reg     <= '0;
          rd_valid_reg <= 1'b0;
        end else begin
          rd_valid_reg <= rd_accept;
          if (rd_accept) dout_reg <= mem_rdata;
        end
      end

      assign dout     = dout_reg;
      assign rd_valid = rd_valid_reg;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Scoreboard bench: a standard-read FIFO and an FWFT FIFO side by side.
module tb_sync_fifo_prog;
  import fifo_pkg::*;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic resetb = 1'b0;
  always #5 clk = ~clk;

  logic          wr_en = 0, rd_en = 0, flush = 0, clr_err = 0;
  logic [DW-1:0] din = '0;
  logic [DW-1:0] dout;
  logic          rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [AW:0]   count;

  logic          f_wr_en = 0, f_rd_en = 0;
  logic [DW-1:0] f_din = '0;
  logic [DW-1:0] f_dout;
  logic          f_rd_valid, f_full, f_empty, f_almost_full, f_almost_empty;
  logic          f_overflow, f_underflow;
  logic [AW:0]   f_count;

  sync_fifo_prog #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(FIFO_MODE_STD)) u_dut (
    .clk(clk), .resetb(resetb), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .flush(flush), .clr_err(clr_err), .dout(dout), .rd_valid(rd_valid),
    .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .overflow(overflow),
    .underflow(underflow)
  );

  sync_fifo_prog #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(FIFO_MODE_FWFT)) u_fwft (
    .clk(clk), .resetb(resetb), .wr_en(f_wr_en), .din(f_din), .rd_en(f_rd_en),
    .flush(1'b0), .clr_err(1'b0), .dout(f_dout), .rd_valid(f_rd_valid),
    .full(f_full), .empty(f_empty), .almost_full(f_almost_full),
    .almost_empty(f_almost_empty), .count(f_count), .overflow(f_overflow),
    .underflow(f_underflow)
  );

  int            n_vec = 0;
  int            n_err = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] last_dout = '0;
  int            mdl_count = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Standard-mode read data is compared when rd_valid shows it.
  always @(negedge clk) begin
    if (resetb && rd_valid) begin
      if (exp_q.size() == 0) begin
        check("rd_valid_unexpected", 32'(rd_valid), 32'd0);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        $display("rd dout=%02h exp=%02h", dout, e);
        check("dout", 32'(dout), 32'(e));
        last_dout = e;
      end
    end
  end

  task automatic step(input logic w, input logic [DW-1:0] d, input logic r);
    logic wa, ra;
    wr_en = w; din = d; rd_en = r;
    wa = w && (mdl_count < DEPTH);
    ra = r && (mdl_count > 0);
    if (wa) exp_q.push_back(d);
    mdl_count = mdl_count + (wa ? 1 : 0) - (ra ? 1 : 0);
    @(posedge clk); #1;
    wr_en = 0; rd_en = 0;
  endtask

  task automatic check_reset_state();
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_ae", 32'(almost_empty), 32'd1);
    check("rst_af", 32'(almost_full), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_udf", 32'(underflow), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    #12;
    check_reset_state();
    check("f_rst_empty", 32'(f_empty), 32'd1);
    check("f_rst_full", 32'(f_full), 32'd0);
    check("f_rst_flags", 32'({f_almost_full, f_almost_empty, f_overflow, f_underflow}), 32'b0100);
    @(negedge clk); resetb = 1;
    @(posedge clk); #1;

    // Fill 0x00..0x0F, then one write too many.
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, DW'(i), 1'b0);
      check("fill_count", 32'(count), 32'(mdl_count));
      check("fill_af", 32'(almost_full), 32'(mdl_count >= 12));
      check("fill_ae", 32'(almost_empty), 32'(mdl_count <= 4));
      check("fill_full", 32'(full), 32'(mdl_count == DEPTH));
    end
    step(1'b1, 8'hAA, 1'b0);
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_count", 32'(count), 32'd16);

    // Drain everything, then one read too many.
    for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1);
    check("drain_empty", 32'(empty), 32'd1);
    step(1'b0, '0, 1'b1);
    check("udf_set", 32'(underflow), 32'd1);
    check("udf_no_valid", 32'(rd_valid), 32'd0);
    #10;
    check("udf_dout_hold", 32'(dout), 32'h0F);

    // Streaming at count 8 across pointer wrap.
    for (int i = 0; i < 8; i++) step(1'b1, DW'(8'h10 + i), 1'b0);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, DW'(8'h40 + i), 1'b1);
      check("stream_count", 32'(count), 32'd8);
    end
    step(1'b1, 8'hB0, 1'b0);
    step(1'b1, 8'hB1, 1'b0);
    check("pre_flush_count", 32'(count), 32'd10);
    check("pre_flush_ovf", 32'(overflow), 32'd1);

    // Flush together with a write: the write is discarded.
    flush = 1; wr_en = 1; din = 8'hEE;
    @(posedge clk); #1;
    flush = 0; wr_en = 0;
    exp_q.delete();
    mdl_count = 0;
    check("flush_count", 32'(count), 32'd0);
    check("flush_empty", 32'(empty), 32'd1);
    check("flush_rd_valid", 32'(rd_valid), 32'd0);
    check("flush_dout_hold", 32'(dout), 32'(last_dout));
    check("flush_ovf_kept", 32'(overflow), 32'd1);
    step(1'b0, '0, 1'b0);
    check("ovf_still", 32'(overflow), 32'd1);
    clr_err = 1;
    step(1'b0, '0, 1'b0);
    clr_err = 0;
    check("clr_ovf", 32'(overflow), 32'd0);
    check("clr_udf", 32'(underflow), 32'd0);
    step(1'b0, '0, 1'b1);
    check("post_flush_udf", 32'(underflow), 32'd1);
    check("post_flush_count", 32'(count), 32'd0);

    // FWFT instance: written word falls through without a read.
    check("f_idle_valid", 32'(f_rd_valid), 32'd0);
    f_wr_en = 1; f_din = 8'h5A;
    @(posedge clk); #1;
    f_wr_en = 0;
    check("f_empty_after_wr", 32'(f_empty), 32'd0);
    check("f_dout", 32'(f_dout), 32'h5A);
    check("f_rd_valid", 32'(f_rd_valid), 32'd1);
    check("f_count", 32'(f_count), 32'd1);
    f_rd_en = 1;
    @(posedge clk); #1;
    f_rd_en = 0;
    check("f_empty_after_rd", 32'(f_empty), 32'd1);
    check("f_valid_after_rd", 32'(f_rd_valid), 32'd0);

    // Asynchronous reset between clock edges with words stored.
    for (int i = 0; i < 5; i++) step(1'b1, DW'(8'hC0 + i), 1'b0);
    check("pre_rst_count", 32'(count), 32'd5);
    @(posedge clk); #3;
    resetb = 0;
    #1;
    check_reset_state();
    exp_q.delete();
    mdl_count = 0;
    @(negedge clk); resetb = 1;
    @(posedge clk); #1;
    step(1'b0, '0, 1'b1);
    check("post_rst_udf", 32'(underflow), 32'd1);
    check("post_rst_count", 32'(count), 32'd0);
    check("post_rst_valid", 32'(rd_valid), 32'd0);

    #20;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
